// File: rtl/sync_pulse_classifier_pkg.sv
// Shared types for the low-pulse classifier.
// Holds the FSM state encoding and the glitch counter width.
package sync_pulse_classifier_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

    localparam int GLITCH_W = 8;

endpackage

// File: rtl/sync_pulse_classifier_sat_counter.sv
// Saturating up-counter with clear, load and increment.
// Clear wins over load, load wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/sync_pulse_classifier.sv
// Measures active-low pulses and classifies them as glitch, short or long.
// Raises stuck_low while a single low episode exceeds the stuck threshold.
module sync_pulse_classifier
    import sync_pulse_classifier_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MIN_WIDTH   = 4,
    parameter int LONG_WIDTH  = 1000,
    parameter int STUCK_WIDTH = 60000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                signal_sn,
    output logic                short_pulse,
    output logic                long_pulse,
    output logic                width_valid,
    output logic [CNT_W-1:0]    width_out,
    output logic                stuck_low,
    output logic [GLITCH_W-1:0] glitch_cnt,
    output logic                busy
);

    state_t state_q;
    state_t state_d;

    logic prev_sn_q;
    logic prev_sn_d;
    logic short_q;
    logic short_d;
    logic long_q;
    logic long_d;
    logic valid_q;
    logic valid_d;
    logic stuck_q;
    logic stuck_d;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] width_d;

    logic [CNT_W-1:0] count;
    logic             cnt_load;
    logic             cnt_inc;
    logic             glitch_inc;

    logic fall;
    logic at_stuck;
    logic is_glitch;
    logic is_long;

    assign prev_sn_d = signal_sn;
    assign fall      = prev_sn_q && !signal_sn;
    assign at_stuck  = (count == CNT_W'(STUCK_WIDTH - 1));
    assign is_glitch = (count < CNT_W'(MIN_WIDTH));
    assign is_long   = (count >= CNT_W'(LONG_WIDTH));

    sat_counter #(
        .W (CNT_W)
    ) u_width_cnt (
        .clk      (clock),
        .rst      (reset),
        .clr      (1'b0),
        .load     (cnt_load),
        .load_val (CNT_W'(1)),
        .inc      (cnt_inc),
        .q        (count)
    );

    sat_counter #(
        .W (GLITCH_W)
    ) u_glitch_cnt (
        .clk      (clock),
        .rst      (reset),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .inc      (glitch_inc),
        .q        (glitch_cnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_sn_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
            width_q   <= '0;
        end else begin
            state_q   <= state_d;
            prev_sn_q <= prev_sn_d;
            short_q   <= short_d;
            long_q    <= long_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
            width_q   <= width_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fall) state_d = MEASURE;
            end
            MEASURE: begin
                if (signal_sn) state_d = IDLE;
                else if (at_stuck) state_d = STUCK;
            end
            STUCK: begin
                if (signal_sn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Release decisions use the count before this edge's sample.
    always_comb begin
        short_d    = 1'b0;
        long_d     = 1'b0;
        valid_d    = 1'b0;
        stuck_d    = stuck_q;
        width_d    = width_q;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        glitch_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_load = fall;
            end
            MEASURE: begin
                if (!signal_sn) begin
                    cnt_inc = 1'b1;
                    if (at_stuck) stuck_d = 1'b1;
                end else if (is_glitch) begin
                    glitch_inc = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    width_d = count;
                    long_d  = is_long;
                    short_d = !is_long;
                end
            end
            STUCK: begin
                if (signal_sn) stuck_d = 1'b0;
            end
            default: begin
                stuck_d = 1'b0;
            end
        endcase
    end

    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign width_valid = valid_q;
    assign width_out   = width_q;
    assign stuck_low   = stuck_q;
    assign busy        = (state_q != IDLE);

endmodule
